// File: rtl/mem_pkg.sv
// Shared store encodings, FSM state type and lane-mask type for the
// data-memory store path.
package mem_pkg;

  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WR_LO = 2'd1,
    ST_WR_HI = 2'd2
  } state_t;

  typedef logic [3:0] lane_mask_t;

endpackage

// File: rtl/store_lane_align.sv
// Combinational byte-lane alignment: expands funct3/offset into an 8-lane
// mask and a 64-bit shifted data image spanning two consecutive words.
module store_lane_align
  import mem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic [31:0] data,
  output logic [7:0]  m8,
  output logic [63:0] d64,
  output logic        legal
);

  lane_mask_t base;

  always_comb begin
    base  = '0;
    legal = 1'b1;
    case (funct3)
      F3_SB:   base = 4'b0001;
      F3_SH:   base = 4'b0011;
      F3_SW:   base = 4'b1111;
      default: legal = 1'b0;
    endcase
    m8  = {4'b0000, base} << off;
    d64 = {32'b0, data} << {off, 3'b000};
  end

endmodule

// File: rtl/store_sequencer.sv
// Sequences one store per handshake onto the byte-lane write port,
// splitting word-crossing stores into a LO then HI word write.
module store_sequencer
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_data,
  input  logic [2:0]            req_funct3,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic [3:0]            mem_we,
  input  logic                  mem_ready,
  output logic                  err,
  output logic                  busy
);

  state_t state, state_nxt;

  logic [7:0]            m8;
  logic [63:0]           d64;
  logic                  legal;
  logic                  accept;
  logic [ADDR_WIDTH-1:0] word_addr;

  logic [ADDR_WIDTH-1:0] lo_addr_q, hi_addr_q;
  logic [7:0]            m8_q;
  logic [63:0]           d64_q;
  logic                  err_q;

  store_lane_align u_align (
    .funct3 (req_funct3),
    .off    (req_addr[1:0]),
    .data   (req_data),
    .m8     (m8),
    .d64    (d64),
    .legal  (legal)
  );

  assign accept    = (state == ST_IDLE) && req_valid;
  assign word_addr = {req_addr[ADDR_WIDTH-1:2], 2'b00};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      err_q <= 1'b0;
    end else begin
      state <= state_nxt;
      err_q <= accept && !legal;
    end
  end

  // Request fields are only consumed in WR_LO/WR_HI, so they carry no reset.
  always_ff @(posedge clk) begin
    if (accept && legal) begin
      lo_addr_q <= word_addr;
      hi_addr_q <= word_addr + ADDR_WIDTH'(4);
      m8_q      <= m8;
      d64_q     <= d64;
    end
  end

  always_comb begin
    state_nxt = state;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = '0;
    case (state)
      ST_IDLE: begin
        if (accept && legal) state_nxt = ST_WR_LO;
      end
      ST_WR_LO: begin
        mem_addr  = lo_addr_q;
        mem_wdata = d64_q[31:0];
        mem_we    = m8_q[3:0];
        if (mem_ready) state_nxt = (m8_q[7:4] != '0) ? ST_WR_HI : ST_IDLE;
      end
      ST_WR_HI: begin
        mem_addr  = hi_addr_q;
        mem_wdata = d64_q[63:32];
        mem_we    = m8_q[7:4];
        if (mem_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign req_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign err       = err_q;

endmodule
